// File: rtl/trap_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : trap_seq_pkg                                               |
// | Brief   : Shared types and constants for the trap entry/return       |
// |           sequencer (state encoding, control-word addresses, vector  |
// |           table base default, one-hot helper).                       |
// | Config  : TRAP_SEQ_AUTOACK_EN adds the ACK state to the encoding.    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package trap_seq_pkg;

`ifndef VECTOR_ADDR
`define VECTOR_ADDR 32'h0000_1000
`endif

   // Word address of the 32-entry vector table unless overridden.
   localparam logic [31:0] VECTOR_BASE_DEFAULT = `VECTOR_ADDR;

   // Control words exposed by the external interrupt block.
   localparam logic [31:0] ADDR_STACK = 32'hFFFF_FFFF;  // return-address stack
   localparam logic [31:0] ADDR_ISR   = 32'hFFFF_FFFE;  // pending-status register
   localparam logic [31:0] ADDR_ACK   = 32'hFFFF_FFFD;  // acknowledge register

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_PUSH,
      ST_ISR_RD,
      ST_ISR_WAIT,
`ifdef TRAP_SEQ_AUTOACK_EN
      ST_ACK,
`endif
      ST_VEC_RD,
      ST_VEC_WAIT,
      ST_POP,
      ST_POP_WAIT,
      ST_REDIR
   } state_e;

   // One-hot mask for an interrupt index, as written to the ack register.
   function automatic logic [31:0] onehot32(input logic [4:0] idx);
      return 32'd1 << idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/trap_seq_prio_enc32.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : prio_enc32                                                 |
// | Brief   : 32-bit lowest-set-bit priority encoder. Bit 0 has the      |
// |           highest priority; valid is low when no bit is set.         |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module prio_enc32 (
   input  logic [31:0] vec_i,
   output logic [4:0]  idx_o,
   output logic        valid_o
);

   // Scan from the top down so the lowest set bit wins last.
   always_comb begin
      idx_o   = 5'd0;
      valid_o = 1'b0;
      for (int i = 31; i >= 0; i--) begin
         if (vec_i[i]) begin
            idx_o   = 5'(i);
            valid_o = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/trap_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : trap_seq                                                   |
// | Brief   : Trap entry / return sequencer. On an accepted trap it      |
// |           pushes the return PC, reads the pending status, picks the  |
// |           lowest pending index, fetches its vector and redirects the |
// |           core. On return it pops the saved PC and redirects.        |
// | Config  : TRAP_SEQ_AUTOACK_EN - write a one-hot acknowledge before   |
// |           the vector fetch (otherwise software acknowledges).        |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module trap_seq
   import trap_seq_pkg::*;
#(
   parameter logic [31:0] VECTOR_BASE = VECTOR_BASE_DEFAULT,
   parameter int          DEPTH_BITS  = 5
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        trap_i,
   input  logic        insn_boundary_i,
   input  logic [31:0] cur_pc_i,
   input  logic        ret_req_i,
   output logic        busy_o,
   output logic        redirect_o,
   output logic [31:0] redirect_pc_o,
   output logic        strobe_o,
   output logic        rw_o,
   output logic [31:0] d_addr_o,
   output logic [31:0] d_wdata_o,
   input  logic [31:0] d_rdata_i,
   output logic        ovf_o,
   output logic        unf_o
);

   localparam int                    MAX_DEPTH   = 2 ** DEPTH_BITS;
   // Deepest level still allowed to accept one more entry is MAX_DEPTH-2.
   localparam logic [DEPTH_BITS-1:0] DEPTH_LIMIT = DEPTH_BITS'(MAX_DEPTH - 1);

   state_e                 state_q, state_d;
   logic [DEPTH_BITS-1:0]  depth_q, depth_d;
   logic [31:0]            pc_q, pc_d;
   logic [4:0]             index_q, index_d;
   logic [31:0]            rpc_q, rpc_d;
   logic [31:0]            addr_q, addr_d;
   logic [31:0]            wdata_q, wdata_d;
   logic                   ovf_q, ovf_d;
   logic                   unf_q, unf_d;

   logic [4:0]             enc_idx;
   logic                   enc_valid;

   prio_enc32 u_prio (
      .vec_i   (d_rdata_i),
      .idx_o   (enc_idx),
      .valid_o (enc_valid)
   );

   // Next-state, bus request and datapath updates for the sequencer.
   always_comb begin
      state_d    = state_q;
      depth_d    = depth_q;
      pc_d       = pc_q;
      index_d    = index_q;
      rpc_d      = rpc_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      ovf_d      = ovf_q;
      unf_d      = unf_q;
      strobe_o   = 1'b0;
      rw_o       = 1'b0;
      redirect_o = 1'b0;
      busy_o     = (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            // A return request takes precedence over a coincident trap.
            if (ret_req_i) begin
               if (depth_q != '0) state_d = ST_POP;
               else               unf_d   = 1'b1;
            end else if (trap_i && insn_boundary_i) begin
               if (depth_q != DEPTH_LIMIT) begin
                  pc_d    = cur_pc_i;
                  state_d = ST_PUSH;
               end else begin
                  ovf_d = 1'b1;
               end
            end
         end
         ST_PUSH: begin
            strobe_o = 1'b1;
            rw_o     = 1'b1;
            addr_d   = ADDR_STACK;
            wdata_d  = pc_q;
            depth_d  = depth_q + DEPTH_BITS'(1);
            state_d  = ST_ISR_RD;
         end
         ST_ISR_RD: begin
            strobe_o = 1'b1;
            addr_d   = ADDR_ISR;
            state_d  = ST_ISR_WAIT;
         end
         ST_ISR_WAIT: begin
            // Nothing pending means a spurious trap; the pushed frame stays
            // for software to unwind.
            if (enc_valid) begin
               index_d = enc_idx;
`ifdef TRAP_SEQ_AUTOACK_EN
               state_d = ST_ACK;
`else
               state_d = ST_VEC_RD;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
`ifdef TRAP_SEQ_AUTOACK_EN
         ST_ACK: begin
            strobe_o = 1'b1;
            rw_o     = 1'b1;
            addr_d   = ADDR_ACK;
            wdata_d  = onehot32(index_q);
            state_d  = ST_VEC_RD;
         end
`endif
         ST_VEC_RD: begin
            strobe_o = 1'b1;
            addr_d   = VECTOR_BASE + {27'd0, index_q};
            state_d  = ST_VEC_WAIT;
         end
         ST_VEC_WAIT: begin
            rpc_d   = d_rdata_i;
            state_d = ST_REDIR;
         end
         ST_POP: begin
            strobe_o = 1'b1;
            addr_d   = ADDR_STACK;
            depth_d  = depth_q - DEPTH_BITS'(1);
            state_d  = ST_POP_WAIT;
         end
         ST_POP_WAIT: begin
            rpc_d   = d_rdata_i;
            state_d = ST_REDIR;
         end
         ST_REDIR: begin
            redirect_o = 1'b1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Address and write data hold their last driven value between requests.
   assign d_addr_o      = addr_d;
   assign d_wdata_o     = wdata_d;
   assign redirect_pc_o = rpc_q;
   assign ovf_o         = ovf_q;
   assign unf_o         = unf_q;

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         depth_q <= '0;
         pc_q    <= 32'd0;
         index_q <= 5'd0;
         rpc_q   <= 32'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         depth_q <= depth_d;
         pc_q    <= pc_d;
         index_q <= index_d;
         rpc_q   <= rpc_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_trap_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_trap_seq                                                |
// | Brief   : Self-checking bench for trap_seq: table of trap entries    |
// |           plus directed return, underflow, overflow, priority,       |
// |           spurious and mid-sequence reset sequences.                 |
// | Config  : honours TRAP_SEQ_AUTOACK_EN.                               |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_trap_seq;
   import trap_seq_pkg::*;

`ifdef TRAP_SEQ_AUTOACK_EN
   localparam int ENTRY_TXN = 4;
   localparam int ENTRY_CYC = 7;
   localparam int TO_VECRD  = 4;
`else
   localparam int ENTRY_TXN = 3;
   localparam int ENTRY_CYC = 6;
   localparam int TO_VECRD  = 3;
`endif
   localparam logic [31:0] VB = VECTOR_BASE_DEFAULT;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        trap_i, insn_boundary_i, ret_req_i;
   logic [31:0] cur_pc_i;
   logic        busy_o, redirect_o, strobe_o, rw_o, ovf_o, unf_o;
   logic [31:0] redirect_pc_o, d_addr_o, d_wdata_o;
   logic [31:0] d_rdata_i;

   int          checks   = 0;
   int          failures = 0;

   logic [31:0] isr_val, pop_val;
   logic [31:0] la [8];
   logic        lrw[8];
   logic [31:0] lwd[8];

   trap_seq dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .trap_i          (trap_i),
      .insn_boundary_i (insn_boundary_i),
      .cur_pc_i        (cur_pc_i),
      .ret_req_i       (ret_req_i),
      .busy_o          (busy_o),
      .redirect_o      (redirect_o),
      .redirect_pc_o   (redirect_pc_o),
      .strobe_o        (strobe_o),
      .rw_o            (rw_o),
      .d_addr_o        (d_addr_o),
      .d_wdata_o       (d_wdata_o),
      .d_rdata_i       (d_rdata_i),
      .ovf_o           (ovf_o),
      .unf_o           (unf_o)
   );

   always #5 clk = ~clk;

   // Vector table contents: entry i holds 0x7C00 + i*0x100 (entry 4 = 0x8000).
   function automatic logic [31:0] resp(input logic [31:0] a);
      if (a == 32'hFFFF_FFFE) return isr_val;
      if (a == 32'hFFFF_FFFF) return pop_val;
      if (a >= VB && a < VB + 32) return 32'h7C00 + ((a - VB) << 8);
      return 32'hDEAD_BEEF;
   endfunction

   // Interrupt-block read port: data valid only the cycle after a read strobe.
   always @(posedge clk) begin
      if (strobe_o && !rw_o) d_rdata_i <= resp(d_addr_o);
      else                   d_rdata_i <= 32'hDEAD_BEEF;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      trap_i = 1'b0; ret_req_i = 1'b0; insn_boundary_i = 1'b0; cur_pc_i = 32'd0;
      reset_n = 1'b0;
      tick(); tick();
      reset_n = 1'b1;
   endtask

   // Runs from the acceptance edge; logs bus requests, the cycle of the
   // redirect pulse (0 if none) and the cycle at which busy dropped.
   task automatic run_seq(output int rcyc, output logic [31:0] rpc,
                          output int nt, output int endc);
      rcyc = 0; rpc = 32'd0; nt = 0; endc = 0;
      for (int c = 1; c <= 16; c++) begin
         tick();
         if (c == 1) begin trap_i = 1'b0; ret_req_i = 1'b0; end
         if (strobe_o && nt < 8) begin
            la[nt] = d_addr_o; lrw[nt] = rw_o; lwd[nt] = d_wdata_o; nt++;
         end
         if (redirect_o && rcyc == 0) begin rcyc = c; rpc = redirect_pc_o; end
         if (!busy_o) begin endc = c; break; end
      end
      if (endc == 0) chk("seq_timeout", 32'd1, 32'd0);
   endtask

   typedef struct {
      logic [31:0] pc;
      logic [31:0] isr;
      logic [4:0]  idx;
      logic [31:0] ack;
      logic [31:0] rpc;
   } entry_t;

   entry_t tbl[5];

   initial begin
      int rc, nt, ec, cnt;
      logic [31:0] rp;

      tbl[0] = '{32'h0000_1234, 32'h0000_0050,  5'd4, 32'h0000_0010, 32'h0000_8000};
      tbl[1] = '{32'h0000_2000, 32'h0000_0001,  5'd0, 32'h0000_0001, 32'h0000_7C00};
      tbl[2] = '{32'hCAFE_0004, 32'h8000_0000, 5'd31, 32'h8000_0000, 32'h0000_9B00};
      tbl[3] = '{32'h0000_3008, 32'h0001_0100,  5'd8, 32'h0000_0100, 32'h0000_8400};
      tbl[4] = '{32'h0000_400C, 32'hFFFE_0000, 5'd17, 32'h0002_0000, 32'h0000_8D00};
      isr_val = 32'd0; pop_val = 32'd0;

      // Reset state.
      do_reset();
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_strobe", {31'd0, strobe_o}, 32'd0);
      chk("rst_redirect", {31'd0, redirect_o}, 32'd0);
      chk("rst_flags", {30'd0, ovf_o, unf_o}, 32'd0);
      chk("rst_rpc", redirect_pc_o, 32'd0);

      // Return at depth 0: no bus activity, underflow flag.
      ret_req_i = 1'b1;
      run_seq(rc, rp, nt, ec);
      chk("unf_txn", nt, 0);
      chk("unf_flag", {31'd0, unf_o}, 32'd1);

      // Trap outside an instruction boundary is not taken.
      do_reset();
      trap_i = 1'b1; insn_boundary_i = 1'b0;
      run_seq(rc, rp, nt, ec);
      chk("nobound_txn", nt, 0);

      // Table of trap entries at increasing depth.
      for (int k = 0; k < 5; k++) begin
         isr_val = tbl[k].isr;
         trap_i = 1'b1; insn_boundary_i = 1'b1; cur_pc_i = tbl[k].pc;
         run_seq(rc, rp, nt, ec);
         chk($sformatf("e%0d_txn", k), nt, ENTRY_TXN);
         chk($sformatf("e%0d_push_addr", k), la[0], 32'hFFFF_FFFF);
         chk($sformatf("e%0d_push_rw", k), {31'd0, lrw[0]}, 32'd1);
         chk($sformatf("e%0d_push_data", k), lwd[0], tbl[k].pc);
         chk($sformatf("e%0d_isr_addr", k), la[1], 32'hFFFF_FFFE);
         chk($sformatf("e%0d_isr_rw", k), {31'd0, lrw[1]}, 32'd0);
`ifdef TRAP_SEQ_AUTOACK_EN
         chk($sformatf("e%0d_ack_addr", k), la[2], 32'hFFFF_FFFD);
         chk($sformatf("e%0d_ack_rw", k), {31'd0, lrw[2]}, 32'd1);
         chk($sformatf("e%0d_ack_data", k), lwd[2], tbl[k].ack);
`endif
         chk($sformatf("e%0d_vec_addr", k), la[ENTRY_TXN-1], VB + {27'd0, tbl[k].idx});
         chk($sformatf("e%0d_vec_rw", k), {31'd0, lrw[ENTRY_TXN-1]}, 32'd0);
         chk($sformatf("e%0d_redir_cyc", k), rc, ENTRY_CYC);
         chk($sformatf("e%0d_redir_pc", k), rp, tbl[k].rpc);
      end
      chk("tbl_flags", {30'd0, ovf_o, unf_o}, 32'd0);

      // Trap and return together at depth 5: return wins.
      pop_val = 32'hABCD_0000;
      trap_i = 1'b1; ret_req_i = 1'b1; insn_boundary_i = 1'b1; cur_pc_i = 32'h5555;
      run_seq(rc, rp, nt, ec);
      chk("both_txn", nt, 1);
      chk("both_addr", la[0], 32'hFFFF_FFFF);
      chk("both_rw", {31'd0, lrw[0]}, 32'd0);
      chk("both_cyc", rc, 3);
      chk("both_pc", rp, 32'hABCD_0000);

      // Single entry then return brings depth back to zero.
      do_reset();
      isr_val = 32'h50; pop_val = 32'h1234;
      trap_i = 1'b1; insn_boundary_i = 1'b1; cur_pc_i = 32'h1234;
      run_seq(rc, rp, nt, ec);
      ret_req_i = 1'b1;
      run_seq(rc, rp, nt, ec);
      chk("ret_txn", nt, 1);
      chk("ret_addr", la[0], 32'hFFFF_FFFF);
      chk("ret_cyc", rc, 3);
      chk("ret_pc", rp, 32'h1234);
      chk("ret_unf_clear", {31'd0, unf_o}, 32'd0);
      ret_req_i = 1'b1;
      run_seq(rc, rp, nt, ec);
      chk("ret_depth0_unf", {31'd0, unf_o}, 32'd1);

      // Spurious trap: no redirect, idle after ISR_WAIT, frame left pushed.
      do_reset();
      isr_val = 32'd0;
      trap_i = 1'b1; insn_boundary_i = 1'b1; cur_pc_i = 32'h7777;
      run_seq(rc, rp, nt, ec);
      chk("spur_txn", nt, 2);
      chk("spur_redir", rc, 0);
      chk("spur_idle_cyc", ec, 4);
      pop_val = 32'h7777;
      ret_req_i = 1'b1;
      run_seq(rc, rp, nt, ec);
      chk("spur_pop_pc", rp, 32'h7777);
      chk("spur_unf", {31'd0, unf_o}, 32'd0);

      // 31 nested entries fill the stack; the next trap is refused.
      do_reset();
      isr_val = 32'h50;
      cnt = 0;
      for (int k = 0; k < 31; k++) begin
         trap_i = 1'b1; insn_boundary_i = 1'b1; cur_pc_i = 32'h100 + k;
         run_seq(rc, rp, nt, ec);
         if (rc == ENTRY_CYC && rp == 32'h8000) cnt++;
      end
      chk("nest_redirs", cnt, 31);
      chk("nest_ovf_before", {31'd0, ovf_o}, 32'd0);
      trap_i = 1'b1; insn_boundary_i = 1'b1;
      run_seq(rc, rp, nt, ec);
      chk("ovf_txn", nt, 0);
      chk("ovf_flag", {31'd0, ovf_o}, 32'd1);

      // Reset asserted while the vector read is on the bus.
      do_reset();
      reset_n = 1'b1;
      isr_val = 32'h50;
      trap_i = 1'b1; insn_boundary_i = 1'b1; cur_pc_i = 32'h1234;
      tick();
      trap_i = 1'b0;
      repeat (TO_VECRD) tick();
      chk("mid_vecrd_strobe", {31'd0, strobe_o}, 32'd1);
      chk("mid_vecrd_addr", d_addr_o, VB + 32'd4);
      reset_n = 1'b0;
      tick();
      chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
      chk("mid_rst_strobe", {31'd0, strobe_o}, 32'd0);
      chk("mid_rst_rpc", redirect_pc_o, 32'd0);
      reset_n = 1'b1;
      ret_req_i = 1'b1;
      run_seq(rc, rp, nt, ec);
      chk("mid_rst_depth0", {31'd0, unf_o}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/trap_seq.md
TRAP_SEQ -- requirements
Module: trap_seq

Interface
REQ-001 Parameter VECTOR_BASE, default `VECTOR_ADDR: word address of the 32-entry vector table.
REQ-002 Parameter DEPTH_BITS, default 5: nesting depth counter width; MAX_DEPTH = 2**DEPTH_BITS.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 trap  in  1  interrupt request from the external interrupt block.
REQ-006 insn_boundary  in  1  core is between instructions and may be redirected.
REQ-007 cur_pc  in  32  return address to save on entry.
REQ-008 ret_req  in  1  core requests return-from-interrupt.
REQ-009 busy  out  1  core shall stall while high.
REQ-010 redirect  out  1  single-cycle pulse that loads redirect_pc into the core PC.
REQ-011 redirect_pc  out  32  new PC.
REQ-012 strobe, rw  out  1 each  bus request to the interrupt block; rw=1 write.
REQ-013 d_addr, d_wdata  out  32 each  bus address and write data.
REQ-014 d_rdata  in  32  read data, valid exactly one cycle after the read strobe.
REQ-015 ovf, unf  out  1 each  sticky nesting overflow / underflow flags.

Function
REQ-016 States: IDLE, PUSH, ISR_RD, ISR_WAIT, ACK, VEC_RD, VEC_WAIT, POP, POP_WAIT, REDIR.
REQ-017 IDLE->PUSH when trap & insn_boundary & !ret_req & depth<MAX_DEPTH-1; at depth==MAX_DEPTH-1, stay IDLE and set ovf.
REQ-018 IDLE->POP when ret_req & depth>0; ret_req at depth 0 stays IDLE and sets unf; ret_req beats a simultaneous trap.
REQ-019 PUSH: strobe=1, rw=1, d_addr=32'hFFFFFFFF, d_wdata=cur_pc captured at acceptance; depth+1.
REQ-020 ISR_RD: strobe=1, rw=0, d_addr=32'hFFFFFFFE; ISR_WAIT: capture d_rdata and select the lowest set bit index (0..31).
REQ-021 ISR value zero (spurious): ISR_WAIT->IDLE, no redirect, depth unchanged from PUSH (software pops).
REQ-022 VEC_RD: strobe=1, rw=0, d_addr=VECTOR_BASE+index; VEC_WAIT: capture d_rdata into redirect_pc; ->REDIR.
REQ-023 POP: strobe=1, rw=0, d_addr=32'hFFFFFFFF; depth-1; POP_WAIT: capture d_rdata into redirect_pc; ->REDIR.
REQ-024 REDIR: redirect=1 for one cycle; ->IDLE.
REQ-025 strobe=0 in IDLE, ISR_WAIT, VEC_WAIT, POP_WAIT, REDIR; d_addr/d_wdata hold last value when strobe=0.
REQ-026 busy=1 in every non-IDLE state; trap and ret_req are ignored outside IDLE.
REQ-027 Latency from acceptance edge: entry redirect in cycle 6 (cycle 7 with ACK); return redirect in cycle 3.
REQ-028 depth arithmetic is DEPTH_BITS wide and never wraps (guarded by REQ-017/018).

Reset
REQ-029 reset_n low at an edge forces IDLE, depth=0, ovf=unf=0, strobe=rw=0, redirect=0, busy=0, redirect_pc=0, even mid-sequence.

Configuration
REQ-030 Macro TRAP_SEQ_AUTOACK_EN defined: ISR_WAIT->ACK; ACK drives strobe=1, rw=1, d_addr=32'hFFFFFFFD, d_wdata=one-hot(index); ACK->VEC_RD.
REQ-031 Macro undefined: ACK state absent, ISR_WAIT->VEC_RD directly; software acknowledges.

Structure
REQ-032 Shared package holds the state enum, control addresses FFFFFFFF/FFFFFFFE/FFFFFFFD, and the VECTOR_BASE default.
REQ-033 Sub-module prio_enc32 (32-bit lowest-set-bit encoder, 5-bit index plus valid) is instantiated once.

Verification
REQ-034 trap=1, insn_boundary=1, cur_pc=0x1234, ISR returns 0x00000050, vector[4]=0x8000 -> write 0x1234 @FFFFFFFF, read @FFFFFFFE, read @VECTOR_BASE+4, redirect_pc=0x8000 in cycle 6.
REQ-035 Same with TRAP_SEQ_AUTOACK_EN -> write 0x10 @FFFFFFFD before vector read, redirect in cycle 7.
REQ-036 depth=1, ret_req=1, pop returns 0x1234 -> read @FFFFFFFF, redirect_pc=0x1234 in cycle 3, depth=0.
REQ-037 ret_req at depth 0 -> no strobe, unf=1; 31 nested entries then trap -> 32nd ignored, ovf=1.
REQ-038 trap and ret_req together at depth 2 -> return sequence only; ISR read 0 -> no redirect, IDLE after ISR_WAIT.
REQ-039 reset_n low during VEC_RD -> next cycle IDLE, strobe=0, busy=0, depth=0.
